fifo_cache_mem: RTL

Responder end of the fifo cache command/response interface; stands in for the DDR memory controller's cache FIFO port.
- Accepts read/write burst commands from the AXI4-to-fifo bridge and serves them from on-chip byte-writable block RAM.
- Returns read beats with backpressure.
- Used for DDR-less bring-up and as the bridge's simulation target.

---
 rtl/fifo_cache_pkg.sv | 23 ++
 rtl/fifo_cache_ram.sv | 57 +++++
 rtl/fifo_cache_mem.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_cache_pkg.sv
// Shared constants and types for the fifo cache responder.
package fifo_cache_pkg;

    localparam logic CMD_WR = 1'b0;
    localparam logic CMD_RD = 1'b1;

    localparam int FIFO_DATA_W  = 128;
    localparam int FIFO_MASK_W  = 16;
    localparam int FIFO_ADDR_W  = 27;
    localparam int FIFO_BURST_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_BURST = 2'd1,
        ST_RD_BURST = 2'd2
    } state_t;

    // The bus uses the DDR data-mask sense (1 = keep); the RAM wants byte enables.
    function automatic logic [FIFO_MASK_W-1:0] mask_to_be(input logic [FIFO_MASK_W-1:0] mask);
        return ~mask;
    endfunction

endpackage

// File: rtl/fifo_cache_ram.sv
// Simple dual-port block RAM: byte-enabled write port, registered read port.
module fifo_cache_ram
    import fifo_cache_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int INIT_ZERO  = 1
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [DEPTH_LOG2-1:0]  wr_addr,
    input  logic [FIFO_DATA_W-1:0] wr_data,
    input  logic [FIFO_MASK_W-1:0] wr_be,
    input  logic                   rd_en,
    input  logic [DEPTH_LOG2-1:0]  rd_addr,
    output logic [FIFO_DATA_W-1:0] rd_data
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    generate
        if (INIT_ZERO != 0) begin : g_zero_init
            // Contents are cleared by the configuration image, never by reset.
            logic [FIFO_DATA_W-1:0] mem_r [0:WORDS-1] = '{default: {FIFO_DATA_W{1'b0}}};

            // Byte-lane writes and one-cycle registered read.
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    for (int b = 0; b < FIFO_MASK_W; b++) begin
                        if (wr_be[b]) begin
                            mem_r[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                        end
                    end
                end
                if (rd_en) begin
                    rd_data <= mem_r[rd_addr];
                end
            end
        end else begin : g_no_init
            logic [FIFO_DATA_W-1:0] mem_r [0:WORDS-1];

            // Byte-lane writes and one-cycle registered read.
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    for (int b = 0; b < FIFO_MASK_W; b++) begin
                        if (wr_be[b]) begin
                            mem_r[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                        end
                    end
                end
                if (rd_en) begin
                    rd_data <= mem_r[rd_addr];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/fifo_cache_mem.sv
// Fifo cache responder: burst command FSM over on-chip RAM with a 2-entry
// skid FIFO on the read response path.
module fifo_cache_mem
    import fifo_cache_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int INIT_ZERO  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fifo_cmd_valid,
    output logic                    fifo_cmd_rdy,
    input  logic                    fifo_cmd_type,
    input  logic [FIFO_ADDR_W-1:0]  fifo_cmd_addr,
    input  logic [FIFO_BURST_W-1:0] fifo_cmd_burst_cnt,
    input  logic [FIFO_DATA_W-1:0]  fifo_cmd_wt_data,
    input  logic [FIFO_MASK_W-1:0]  fifo_cmd_wt_mask,
    output logic                    fifo_rsp_valid,
    input  logic                    fifo_rsp_rdy,
    output logic [FIFO_DATA_W-1:0]  fifo_rsp_data
);

    localparam logic [DEPTH_LOG2-1:0] WORD_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    state_t                  state_r;
    logic                    cmd_rdy_r;
    logic [DEPTH_LOG2-1:0]   word_addr_r;      // next word to write or to read
    logic [FIFO_BURST_W-1:0] wr_left_r;        // write beats still expected
    logic [FIFO_BURST_W-1:0] rd_len_r;         // index of the last read beat
    logic [FIFO_BURST_W:0]   rd_issue_left_r;  // RAM reads still to issue
    logic [FIFO_BURST_W-1:0] rd_beat_r;        // index of next beat to hand off
    logic                    rd_inflight_r;    // RAM output holds a fresh word
    logic [1:0]              fifo_occ_r;
    logic [FIFO_DATA_W-1:0]  fifo_ent0_r;      // head entry, drives the response bus
    logic [FIFO_DATA_W-1:0]  fifo_ent1_r;
    logic                    rsp_valid_r;

    logic                    cmd_fire_s;
    logic [DEPTH_LOG2-1:0]   cmd_word_s;
    logic                    pop_s;
    logic                    push_s;
    logic                    rd_en_s;
    logic                    ram_wr_en_s;
    logic [DEPTH_LOG2-1:0]   ram_wr_addr_s;
    logic [FIFO_DATA_W-1:0]  ram_rd_data_s;
    logic [1:0]              fifo_occ_nxt_s;
    logic [FIFO_DATA_W-1:0]  fifo_ent0_nxt_s;
    logic [FIFO_DATA_W-1:0]  fifo_ent1_nxt_s;
    logic                    unused_addr_bits_s;

    // Byte offset and bits above the RAM size carry no meaning here.
    assign unused_addr_bits_s = ^{fifo_cmd_addr[FIFO_ADDR_W-1:DEPTH_LOG2+4], fifo_cmd_addr[3:0]};

    assign cmd_word_s = fifo_cmd_addr[DEPTH_LOG2+3:4];
    // A beat presented on a reset edge is dropped, so reset never commits a write.
    assign cmd_fire_s = fifo_cmd_valid && cmd_rdy_r && !rst;
    assign pop_s      = rsp_valid_r && fifo_rsp_rdy;
    assign push_s     = rd_inflight_r;

    assign fifo_cmd_rdy   = cmd_rdy_r;
    assign fifo_rsp_valid = rsp_valid_r;
    assign fifo_rsp_data  = fifo_ent0_r;

    // RAM write port: first beat addressed by the command, later beats by the counter.
    always_comb begin
        ram_wr_en_s   = 1'b0;
        ram_wr_addr_s = word_addr_r;
        if (cmd_fire_s) begin
            if (state_r == ST_IDLE) begin
                ram_wr_en_s   = (fifo_cmd_type == CMD_WR);
                ram_wr_addr_s = cmd_word_s;
            end else begin
                ram_wr_en_s   = 1'b1;
                ram_wr_addr_s = word_addr_r;
            end
        end else begin
            ram_wr_en_s   = 1'b0;
            ram_wr_addr_s = word_addr_r;
        end
    end

    // Issue a read while the skid FIFO has room; a beat leaving this edge frees its slot.
    always_comb begin
        rd_en_s = 1'b0;
        if ((state_r == ST_RD_BURST) && (rd_issue_left_r != 7'd0) && !rst) begin
            rd_en_s = (({1'b0, fifo_occ_r} + {2'b00, rd_inflight_r}) < (3'd2 + {2'b00, pop_s}));
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Skid FIFO next-state: shift on pop, RAM word lands in the first free slot.
    always_comb begin
        fifo_occ_nxt_s  = fifo_occ_r;
        fifo_ent0_nxt_s = fifo_ent0_r;
        fifo_ent1_nxt_s = fifo_ent1_r;
        case ({push_s, pop_s})
            2'b01: begin
                fifo_occ_nxt_s  = fifo_occ_r - 2'd1;
                fifo_ent0_nxt_s = fifo_ent1_r;
            end
            2'b10: begin
                fifo_occ_nxt_s = fifo_occ_r + 2'd1;
                if (fifo_occ_r == 2'd0) begin
                    fifo_ent0_nxt_s = ram_rd_data_s;
                end else begin
                    fifo_ent1_nxt_s = ram_rd_data_s;
                end
            end
            2'b11: begin
                if (fifo_occ_r == 2'd1) begin
                    fifo_ent0_nxt_s = ram_rd_data_s;
                end else begin
                    fifo_ent0_nxt_s = fifo_ent1_r;
                    fifo_ent1_nxt_s = ram_rd_data_s;
                end
            end
            default: begin
                fifo_occ_nxt_s = fifo_occ_r;
            end
        endcase
    end

    // Command FSM, burst counters and skid FIFO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            cmd_rdy_r       <= 1'b0;
            word_addr_r     <= '0;
            wr_left_r       <= 6'd0;
            rd_len_r        <= 6'd0;
            rd_issue_left_r <= 7'd0;
            rd_beat_r       <= 6'd0;
            rd_inflight_r   <= 1'b0;
            fifo_occ_r      <= 2'd0;
            fifo_ent0_r     <= {FIFO_DATA_W{1'b0}};
            fifo_ent1_r     <= {FIFO_DATA_W{1'b0}};
            rsp_valid_r     <= 1'b0;
        end else begin
            rd_inflight_r <= rd_en_s;
            fifo_occ_r    <= fifo_occ_nxt_s;
            fifo_ent0_r   <= fifo_ent0_nxt_s;
            fifo_ent1_r   <= fifo_ent1_nxt_s;
            rsp_valid_r   <= (fifo_occ_nxt_s != 2'd0);
            case (state_r)
                ST_IDLE: begin
                    cmd_rdy_r <= 1'b1;
                    if (cmd_fire_s) begin
                        if (fifo_cmd_type == CMD_WR) begin
                            word_addr_r <= cmd_word_s + WORD_ONE;
                            wr_left_r   <= fifo_cmd_burst_cnt;
                            if (fifo_cmd_burst_cnt != 6'd0) begin
                                state_r <= ST_WR_BURST;
                            end
                        end else begin
                            word_addr_r     <= cmd_word_s;
                            rd_len_r        <= fifo_cmd_burst_cnt;
                            rd_issue_left_r <= {1'b0, fifo_cmd_burst_cnt} + 7'd1;
                            rd_beat_r       <= 6'd0;
                            cmd_rdy_r       <= 1'b0;
                            state_r         <= ST_RD_BURST;
                        end
                    end
                end
                ST_WR_BURST: begin
                    cmd_rdy_r <= 1'b1;
                    if (cmd_fire_s) begin
                        word_addr_r <= word_addr_r + WORD_ONE;
                        wr_left_r   <= wr_left_r - 6'd1;
                        if (wr_left_r == 6'd1) begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_RD_BURST: begin
                    cmd_rdy_r <= 1'b0;
                    if (rd_en_s) begin
                        word_addr_r     <= word_addr_r + WORD_ONE;
                        rd_issue_left_r <= rd_issue_left_r - 7'd1;
                    end
                    if (pop_s) begin
                        rd_beat_r <= rd_beat_r + 6'd1;
                        if (rd_beat_r == rd_len_r) begin
                            state_r   <= ST_IDLE;
                            cmd_rdy_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cmd_rdy_r <= 1'b0;
                end
            endcase
        end
    end

    fifo_cache_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INIT_ZERO  (INIT_ZERO)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en_s),
        .wr_addr (ram_wr_addr_s),
        .wr_data (fifo_cmd_wt_data),
        .wr_be   (mask_to_be(fifo_cmd_wt_mask)),
        .rd_en   (rd_en_s),
        .rd_addr (word_addr_r),
        .rd_data (ram_rd_data_s)
    );

endmodule
